implication_monitor: RTL and testbench
======================================

// Module: implication_monitor
// PURPOSE
//   Synthesizable run-time checker for "ante |-> ##DELAY cons" on CLK.
//   Checks in silicon and in emulation the same obligations that the inline SVA checks in simulation.
//   Instantiated beside the monitored logic. Outputs feed the debug status CSR block.
// PARAMETERS
//   DELAY  1   cycles from antecedent sample to consequent check; legal 1..16
//   CNT_W  8   width of saturating violation counter
//   TS_W   16  width of free-running cycle timestamp
// PORTS
//   CLK          in   1      clock; all sampling on posedge
//   ASYNCRESETN  in   1      asynchronous active-low reset; deassertion is synchronised upstream
//   en           in   1      1 = new antecedents accepted; outstanding obligations are checked regardless
//   ante         in   1      antecedent
//   cons         in   1      consequent
//   clr          in   1      synchronous clear of status and of all outstanding obligations
//   violation    out  1      one-cycle pulse per failed obligation
//   err          out  1      sticky: any violation since reset or last clr
//   viol_count   out  CNT_W  number of violations, saturating at all-ones
//   first_valid  out  1      first_ts holds a captured value
//   first_ts     out  TS_W   timestamp of first violation since reset or clr
//   pending      out  1      at least one obligation outstanding
// BEHAVIOUR
//   - Reset values: all outputs 0, obligation pipe empty, timestamp counter 0.
//   - Timestamp ts: increments every edge and wraps 2^TS_W-1 -> 0. It is not affected by clr.
//   - Obligation raise: en & ante sampled at edge k sets pend[0].
//   - Obligation shift: pend[i] -> pend[i+1] every edge.
//   - Obligation check: the obligation matures at pend[DELAY-1] and is checked against cons sampled at edge k+DELAY.
//   - Overlap: back-to-back antecedents create independent obligations. Each is checked once; none is merged.
//   - Failure at edge k+DELAY (matured & !cons):
//       - violation = 1 for exactly the cycle after that edge;
//       - err <= 1;
//       - viol_count <= viol_count + 1 unless it is all-ones;
//       - if !first_valid: first_ts <= ts value at that edge, and first_valid <= 1.
//   - A matured obligation with cons = 1 retires silently.
//   - A cons pulse with no matured obligation has no effect.
//   - clr at edge e:
//       - clears err, viol_count, first_valid, first_ts and the whole obligation pipe;
//       - violation is 0 next cycle;
//       - clr wins over a simultaneous failure, which is dropped and not counted;
//       - ante at the same edge is also dropped.
//   - pending = |pend (registered state, no combinational path from ante).
//   - en falling with obligations outstanding: those obligations still mature and are checked.
//   - Reset mid-operation: all obligations are discarded with no violation; outputs return to reset values asynchronously.
//   - No combinational input->output paths. All outputs are registered.
//   - Parameter check: DELAY outside 1..16 is an elaboration error.
// STRUCTURE
//   Shared package implication_monitor_pkg:
//     - MAX_DELAY = 16;
//     - typedef struct monitor_status_t {err, first_valid, viol_count, first_ts}, parameterised through localparam widths for CSR mapping.
//   Sub-module obligation_pipe (DELAY-deep shift register):
//     - inputs push, flush;
//     - outputs matured, any.
//   The top level holds the timestamp counter, the status registers and the violation logic.
// TESTING
//   1. DELAY=1: ante=1 @t0, cons=1 @t1 -> violation stays 0, err=0, pending high one cycle.
//   2. DELAY=1: ante=1 @t0, cons=0 @t1 with ts=5 at t1
//        -> violation pulse one cycle after t1, err=1, viol_count=1, first_ts=5, first_valid=1.
//   3. DELAY=3: ante high t0..t2, cons=1 @t3,t5 and 0 @t4
//        -> exactly one violation (for the t1 obligation), viol_count=1.
//   4. CNT_W=2: 5 consecutive failures -> viol_count 1,2,3,3,3; first_ts frozen at the first failure.
//   5. clr coincident with a failing check edge -> no violation, viol_count=0, err=0, pending=0.
//        The next failure captures a new first_ts.
//   6. en=0 with ante=1 -> no obligation created.
//      ASYNCRESETN low mid-pipe (pending=1) -> all outputs 0 immediately; no violation after release.

Source files
------------

// File: rtl/implication_monitor_pkg.sv
// Shared definitions for the implication monitor: delay limits and the
// status record layout consumed by the debug CSR block.
package implication_monitor_pkg;

  localparam int MAX_DELAY    = 16;
  localparam int STATUS_CNT_W = 8;
  localparam int STATUS_TS_W  = 16;

  typedef struct packed {
    logic                    err;
    logic                    first_valid;
    logic [STATUS_CNT_W-1:0] viol_count;
    logic [STATUS_TS_W-1:0]  first_ts;
  } monitor_status_t;

  function automatic logic delay_ok(input int d);
    return (d >= 1) && (d <= MAX_DELAY);
  endfunction

endpackage

// File: rtl/implication_monitor_obligation_pipe.sv
// DELAY-deep shift register of outstanding obligations; each bit is one
// antecedent in flight, so overlapping antecedents never merge.
module obligation_pipe
  import implication_monitor_pkg::*;
#(
  parameter int DELAY = 1
) (
  input  logic CLK,
  input  logic ASYNCRESETN,
  input  logic push,
  input  logic flush,
  output logic matured,
  output logic any
);

  logic [DELAY-1:0] pend_reg;
  logic [DELAY-1:0] pend_next;

  assign pend_next[0] = push & ~flush;

  for (genvar gi = 1; gi < DELAY; gi++) begin : g_shift
    assign pend_next[gi] = pend_reg[gi-1] & ~flush;
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  assign matured = pend_reg[DELAY-1];
  assign any     = |pend_reg;

endmodule

// File: rtl/implication_monitor.sv
// Run-time checker for "ante |-> ##DELAY cons": timestamp counter, sticky
// status, saturating violation count and first-failure timestamp capture.
module implication_monitor
  import implication_monitor_pkg::*;
#(
  parameter int DELAY = 1,
  parameter int CNT_W = 8,
  parameter int TS_W  = 16
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             en,
  input  logic             ante,
  input  logic             cons,
  input  logic             clr,
  output logic             violation,
  output logic             err,
  output logic [CNT_W-1:0] viol_count,
  output logic             first_valid,
  output logic [TS_W-1:0]  first_ts,
  output logic             pending
);

  if (!delay_ok(DELAY)) begin : g_bad_delay
    $error("implication_monitor: DELAY=%0d outside 1..%0d", DELAY, MAX_DELAY);
  end

  logic             matured;
  logic             pend_any;
  logic             fail;
  logic [TS_W-1:0]  ts_reg;
  logic             violation_reg;
  logic             err_reg;
  logic [CNT_W-1:0] viol_count_reg;
  logic             first_valid_reg;
  logic [TS_W-1:0]  first_ts_reg;

  obligation_pipe #(
    .DELAY(DELAY)
  ) u_pipe (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .push        (en & ante),
    .flush       (clr),
    .matured     (matured),
    .any         (pend_any)
  );

  // clr takes priority: a failure checked on the clearing edge is dropped
  assign fail = matured & ~cons & ~clr;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      ts_reg          <= '0;
      violation_reg   <= 1'b0;
      err_reg         <= 1'b0;
      viol_count_reg  <= '0;
      first_valid_reg <= 1'b0;
      first_ts_reg    <= '0;
    end else begin
      ts_reg <= ts_reg + TS_W'(1);
      if (clr) begin
        violation_reg   <= 1'b0;
        err_reg         <= 1'b0;
        viol_count_reg  <= '0;
        first_valid_reg <= 1'b0;
        first_ts_reg    <= '0;
      end else begin
        violation_reg <= fail;
        if (fail) begin
          err_reg <= 1'b1;
          if (viol_count_reg != {CNT_W{1'b1}}) begin
            viol_count_reg <= viol_count_reg + CNT_W'(1);
          end
          if (!first_valid_reg) begin
            first_valid_reg <= 1'b1;
            first_ts_reg    <= ts_reg;
          end
        end
      end
    end
  end

  assign violation   = violation_reg;
  assign err         = err_reg;
  assign viol_count  = viol_count_reg;
  assign first_valid = first_valid_reg;
  assign first_ts    = first_ts_reg;
  assign pending     = pend_any;

endmodule

// File: tb/tb_implication_monitor.sv
// Scoreboard bench for implication_monitor: two instances (DELAY=1/CNT_W=2
// and DELAY=3/CNT_W=8) share stimulus and are checked against a model.
module tb_implication_monitor;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic ASYNCRESETN, en, ante, cons, clr;

  logic        d1_violation, d1_err, d1_first_valid, d1_pending;
  logic [1:0]  d1_viol_count;
  logic [15:0] d1_first_ts;
  logic        d3_violation, d3_err, d3_first_valid, d3_pending;
  logic [7:0]  d3_viol_count;
  logic [15:0] d3_first_ts;

  implication_monitor #(.DELAY(1), .CNT_W(2), .TS_W(16)) u_d1 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .en(en), .ante(ante),
    .cons(cons), .clr(clr), .violation(d1_violation), .err(d1_err),
    .viol_count(d1_viol_count), .first_valid(d1_first_valid),
    .first_ts(d1_first_ts), .pending(d1_pending)
  );

  implication_monitor #(.DELAY(3), .CNT_W(8), .TS_W(16)) u_d3 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .en(en), .ante(ante),
    .cons(cons), .clr(clr), .violation(d3_violation), .err(d3_err),
    .viol_count(d3_viol_count), .first_valid(d3_first_valid),
    .first_ts(d3_first_ts), .pending(d3_pending)
  );

  typedef struct {
    int   cyc;
    int   m;
    logic viol;
    logic err;
    int   cnt;
    logic fv;
    int   fts;
    logic pend;
  } exp_t;

  typedef struct {
    int m;
    int due;
  } obl_t;

  exp_t sb_q[$];
  obl_t obl_q[$];
  int   edge_count = 0;
  int   n_vectors = 0;
  int   n_miscompares = 0;

  int   m_ts;
  logic m_err [2];
  int   m_cnt [2];
  logic m_fv  [2];
  int   m_fts [2];

  function automatic int m_delay(input int m);
    return (m == 0) ? 1 : 3;
  endfunction

  function automatic int m_cmax(input int m);
    return (m == 0) ? 3 : 255;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_count);
    end
  endtask

  task automatic model_reset();
    obl_q.delete();
    m_ts = 0;
    for (int m = 0; m < 2; m++) begin
      m_err[m] = 1'b0;
      m_cnt[m] = 0;
      m_fv[m]  = 1'b0;
      m_fts[m] = 0;
    end
  endtask

  task automatic check_zero(input string tag);
    check_value({tag, ".d1_viol"}, 32'(d1_violation), 0);
    check_value({tag, ".d1_err"},  32'(d1_err), 0);
    check_value({tag, ".d1_cnt"},  32'(d1_viol_count), 0);
    check_value({tag, ".d1_fv"},   32'(d1_first_valid), 0);
    check_value({tag, ".d1_fts"},  32'(d1_first_ts), 0);
    check_value({tag, ".d1_pend"}, 32'(d1_pending), 0);
    check_value({tag, ".d3_viol"}, 32'(d3_violation), 0);
    check_value({tag, ".d3_err"},  32'(d3_err), 0);
    check_value({tag, ".d3_cnt"},  32'(d3_viol_count), 0);
    check_value({tag, ".d3_fv"},   32'(d3_first_valid), 0);
    check_value({tag, ".d3_fts"},  32'(d3_first_ts), 0);
    check_value({tag, ".d3_pend"}, 32'(d3_pending), 0);
  endtask

  // Drive one edge worth of inputs and queue what each DUT should show after it
  task automatic drive(input logic e, input logic a, input logic c, input logic cl);
    int   nxt;
    obl_t keep[$];
    logic mat [2];
    exp_t x;
    en = e; ante = a; cons = c; clr = cl;
    nxt = edge_count + 1;
    mat[0] = 1'b0;
    mat[1] = 1'b0;
    foreach (obl_q[i]) begin
      if (obl_q[i].due == nxt) mat[obl_q[i].m] = 1'b1;
      else keep.push_back(obl_q[i]);
    end
    obl_q = keep;
    if (cl) obl_q.delete();
    for (int m = 0; m < 2; m++) begin
      x.cyc = nxt;
      x.m   = m;
      if (cl) begin
        x.viol   = 1'b0;
        m_err[m] = 1'b0;
        m_cnt[m] = 0;
        m_fv[m]  = 1'b0;
        m_fts[m] = 0;
      end else begin
        x.viol = mat[m] & ~c;
        if (x.viol) begin
          m_err[m] = 1'b1;
          if (m_cnt[m] < m_cmax(m)) m_cnt[m]++;
          if (!m_fv[m]) begin
            m_fv[m]  = 1'b1;
            m_fts[m] = m_ts;
          end
        end
        if (e && a) obl_q.push_back('{m, nxt + m_delay(m)});
      end
      x.err  = m_err[m];
      x.cnt  = m_cnt[m];
      x.fv   = m_fv[m];
      x.fts  = m_fts[m];
      x.pend = 1'b0;
      foreach (obl_q[i]) if (obl_q[i].m == m) x.pend = 1'b1;
      sb_q.push_back(x);
    end
    m_ts = (m_ts + 1) % 65536;
    @(posedge CLK);
    #1;
  endtask

  always @(posedge CLK) edge_count <= edge_count + 1;

  always @(negedge CLK) begin
    exp_t x;
    while (sb_q.size() > 0 && sb_q[0].cyc <= edge_count) begin
      x = sb_q.pop_front();
      if (x.m == 0) begin
        $display("txn edge=%0d d1 viol=%b err=%b cnt=%0d fv=%b fts=%0d pend=%b",
                 x.cyc, d1_violation, d1_err, d1_viol_count, d1_first_valid,
                 d1_first_ts, d1_pending);
        check_value("d1.viol", 32'(d1_violation), 32'(x.viol));
        check_value("d1.err",  32'(d1_err), 32'(x.err));
        check_value("d1.cnt",  32'(d1_viol_count), x.cnt);
        check_value("d1.fv",   32'(d1_first_valid), 32'(x.fv));
        check_value("d1.fts",  32'(d1_first_ts), x.fts);
        check_value("d1.pend", 32'(d1_pending), 32'(x.pend));
      end else begin
        $display("txn edge=%0d d3 viol=%b err=%b cnt=%0d fv=%b fts=%0d pend=%b",
                 x.cyc, d3_violation, d3_err, d3_viol_count, d3_first_valid,
                 d3_first_ts, d3_pending);
        check_value("d3.viol", 32'(d3_violation), 32'(x.viol));
        check_value("d3.err",  32'(d3_err), 32'(x.err));
        check_value("d3.cnt",  32'(d3_viol_count), x.cnt);
        check_value("d3.fv",   32'(d3_first_valid), 32'(x.fv));
        check_value("d3.fts",  32'(d3_first_ts), x.fts);
        check_value("d3.pend", 32'(d3_pending), 32'(x.pend));
      end
    end
  end

  initial begin
    ASYNCRESETN = 1'b0;
    en = 1'b0; ante = 1'b0; cons = 1'b0; clr = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset");
    model_reset();
    ASYNCRESETN = 1'b1;

    // DELAY=1 pass: ante at ts0, cons at ts1
    drive(1, 1, 1, 0);
    repeat (3) drive(0, 0, 1, 0);
    // DELAY=1 fail with the check edge at ts=5
    drive(1, 1, 1, 0);
    drive(0, 0, 0, 0);
    check_value("t2.fts", 32'(d1_first_ts), 5);
    check_value("t2.cnt", 32'(d1_viol_count), 1);
    repeat (2) drive(0, 0, 1, 0);
    drive(0, 0, 1, 1);

    // DELAY=3 overlap: only the middle obligation fails
    repeat (3) drive(1, 1, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    check_value("t3.d3cnt", 32'(d3_viol_count), 1);
    check_value("t3.d1cnt", 32'(d1_viol_count), 0);
    drive(0, 0, 1, 1);

    // Saturation on CNT_W=2
    repeat (5) drive(1, 1, 0, 0);
    drive(0, 0, 0, 0);
    check_value("t4.sat", 32'(d1_viol_count), 3);
    repeat (3) drive(0, 0, 1, 0);

    // clr on the failing check edge
    drive(1, 1, 0, 0);
    drive(0, 0, 0, 1);
    check_value("t5.viol", 32'(d1_violation), 0);
    check_value("t5.err",  32'(d1_err), 0);
    check_value("t5.pend", 32'(d1_pending), 0);
    drive(1, 1, 1, 0);
    drive(0, 0, 0, 0);
    check_value("t5.fv", 32'(d1_first_valid), 1);

    // en=0 blocks new obligations
    repeat (2) drive(0, 1, 0, 0);
    check_value("t6.pend", 32'(d1_pending), 0);
    repeat (4) drive(0, 0, 1, 0);

    // Asynchronous reset with obligations in flight
    drive(1, 1, 1, 0);
    check_value("t6.d3pend", 32'(d3_pending), 1);
    @(negedge CLK);
    #1;
    ASYNCRESETN = 1'b0;
    #1;
    check_zero("midrst");
    en = 1'b0; ante = 1'b0; cons = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    ASYNCRESETN = 1'b1;
    repeat (5) drive(0, 0, 0, 0);

    @(negedge CLK);
    #1;
    check_value("sb_drained", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
